// File: rtl/note_detector_pkg.sv
// note_pkg: note table and enums shared by the tone player and detector.
// Nominal periods are in 50 MHz clock cycles, C4..A4.
package note_pkg;

  localparam int NUM_NOTES = 6;
  localparam int NOM_W     = 18;

  typedef logic [NOM_W-1:0] nom_t;

  typedef enum logic [2:0] {
    NOTE_C4 = 3'd0,
    NOTE_D4 = 3'd1,
    NOTE_E4 = 3'd2,
    NOTE_F4 = 3'd3,
    NOTE_G4 = 3'd4,
    NOTE_A4 = 3'd5
  } note_e;

  typedef enum logic [1:0] {
    ST_SILENT = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Nominal period of note i in clock cycles.
  function automatic nom_t note_nom(input int unsigned i);
    nom_t n;
    case (i)
      0:       n = 18'd191113;
      1:       n = 18'd170265;
      2:       n = 18'd151685;
      3:       n = 18'd143172;
      4:       n = 18'd127551;
      5:       n = 18'd113636;
      default: n = '0;
    endcase
    return n;
  endfunction

  // One-hot LED pattern for a note index.
  function automatic logic [NUM_NOTES-1:0] onehot(input note_e n);
    return NUM_NOTES'(1) << n;
  endfunction

endpackage

// File: rtl/note_detector_period_meter.sv
// period_meter: synchronizes the sound line, detects rising edges and
// measures the rise-to-rise period with a saturating counter.
module period_meter #(
  parameter int CNT_W = 18
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_sound,
  output logic [CNT_W:0] o_period,
  output logic           o_period_vld,
  output logic           o_timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [CNT_W-1:0] r_cnt;
  logic             r_armed;

  logic w_rise;
  logic w_sat;

  assign w_rise = r_s2 & ~r_s3;
  assign w_sat  = (r_cnt == CNT_MAX);

  // Synchronizer, edge-detect flop, saturating counter and arming flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_cnt   <= '0;
      r_armed <= 1'b0;
    end else begin
      r_s1 <= i_sound;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (w_rise)
        r_cnt <= '0;
      else if (!w_sat)
        r_cnt <= r_cnt + 1'b1;
      if (w_rise)
        r_armed <= 1'b1;
      else if (w_sat)
        r_armed <= 1'b0;
    end
  end

  // A rise coinciding with saturation re-arms but is not a measurement.
  assign o_period     = {1'b0, r_cnt} + (CNT_W+1)'(1);
  assign o_period_vld = w_rise & r_armed & ~w_sat;
  assign o_timeout    = w_sat;

endmodule

// File: rtl/note_detector.sv
// note_detector: classifies sound_in periods against the note table and
// locks after STABLE_N matches. NOTE_DET_HOLD_EN keeps idx/LEDs on timeout.
module note_detector
  import note_pkg::*;
#(
  parameter int CNT_W     = 18,
  parameter int TOL_SHIFT = 6,
  parameter int STABLE_N  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sound_in,
  output logic       note_valid,
  output logic [2:0] note_idx,
  output logic       note_strobe,
  output logic       led0,
  output logic       led1,
  output logic       led2,
  output logic       led3,
  output logic       led4,
  output logic       led5
);

  localparam logic [3:0] STABLE = 4'(STABLE_N);

  logic [CNT_W:0] w_period;
  logic           w_pvld;
  logic           w_timeout;

  period_meter #(
    .CNT_W (CNT_W)
  ) u_meter (
    .clk          (clk),
    .rst          (rst),
    .i_sound      (sound_in),
    .o_period     (w_period),
    .o_period_vld (w_pvld),
    .o_timeout    (w_timeout)
  );

  logic                 w_hit;
  note_e                w_match;
  logic [3:0]           w_run;
  logic                 w_drop;
  logic                 w_adv;

  state_e               r_state;
  note_e                r_cand;
  logic [3:0]           r_mcnt;
  logic                 r_valid;
  note_e                r_idx;
  logic                 r_strobe;
  logic [NUM_NOTES-1:0] r_leds;

  // Window match; scanning downward lets the lowest index win.
  always_comb begin
    logic [CNT_W:0] v_nom;
    logic [CNT_W:0] v_diff;
    w_hit   = 1'b0;
    w_match = NOTE_C4;
    v_nom   = '0;
    v_diff  = '0;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      v_nom  = (CNT_W+1)'(note_nom(i));
      v_diff = (w_period >= v_nom) ? w_period - v_nom
                                   : v_nom - w_period;
      if (v_diff <= (v_nom >> TOL_SHIFT)) begin
        w_hit   = 1'b1;
        w_match = note_e'(i[2:0]);
      end
    end
  end

  // Next match count and which kind of measured event this is.
  always_comb begin
    w_run  = 4'd1;
    if (r_state == ST_TRACK && w_match == r_cand)
      w_run = r_mcnt + 4'd1;
    w_drop = w_pvld & ~w_hit;
    w_adv  = w_pvld & w_hit &
             ~(r_state == ST_LOCKED && w_match == r_idx);
  end

  // Tracking FSM with registered note outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_SILENT;
      r_cand   <= NOTE_C4;
      r_mcnt   <= '0;
      r_valid  <= 1'b0;
      r_idx    <= NOTE_C4;
      r_strobe <= 1'b0;
      r_leds   <= '0;
    end else begin
      r_strobe <= 1'b0;
      if (w_timeout) begin
        r_state <= ST_SILENT;
        r_mcnt  <= '0;
        r_valid <= 1'b0;
`ifndef NOTE_DET_HOLD_EN
        r_idx   <= NOTE_C4;
        r_leds  <= '0;
`endif
      end else if (w_drop) begin
        r_state <= (r_state == ST_LOCKED) ? ST_TRACK : ST_SILENT;
        r_mcnt  <= '0;
      end else if (w_adv) begin
        r_cand <= w_match;
        r_mcnt <= w_run;
        if (w_run >= STABLE) begin
          r_state  <= ST_LOCKED;
          r_idx    <= w_match;
          r_valid  <= 1'b1;
          r_strobe <= 1'b1;
          r_leds   <= onehot(w_match);
        end else begin
          r_state <= ST_TRACK;
        end
      end
    end
  end

  assign note_valid  = r_valid;
  assign note_idx    = r_idx;
  assign note_strobe = r_strobe;
  assign led0        = r_leds[0];
  assign led1        = r_leds[1];
  assign led2        = r_leds[2];
  assign led3        = r_leds[3];
  assign led4        = r_leds[4];
  assign led5        = r_leds[5];

endmodule

// File: tb/tb_note_detector.sv
// tb_note_detector: drives square waves and checks against a
// period-run reference model of the detector.
module tb_note_detector;

  localparam int CNT_MAX = 262143;
  localparam int STABLE  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       sound_in;
  logic       note_valid;
  logic [2:0] note_idx;
  logic       note_strobe;
  logic       led0, led1, led2, led3, led4, led5;

  note_detector dut (
    .clk         (clk),
    .rst         (rst),
    .sound_in    (sound_in),
    .note_valid  (note_valid),
    .note_idx    (note_idx),
    .note_strobe (note_strobe),
    .led0        (led0),
    .led1        (led1),
    .led2        (led2),
    .led3        (led3),
    .led4        (led4),
    .led5        (led5)
  );

  always #5 clk = ~clk;

  int tests   = 0;
  int fails   = 0;
  int strobes = 0;

  always @(negedge clk)
    if (note_strobe === 1'b1) strobes++;

  initial begin
    #(150_000_000);
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  // Reference model: runs of identical matching periods.
  int nom [6] = '{191113, 170265, 151685, 143172, 127551, 113636};
  bit m_armed, m_valid, m_ledon, m_inlock;
  int m_idx, m_run, m_cls, prev_p, exp_strb;

  function automatic int classify(input int p);
    int d;
    for (int i = 0; i < 6; i++) begin
      d = p - nom[i];
      if (d < 0) d = -d;
      if (d <= nom[i] / 64) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_armed = 0; m_valid = 0; m_ledon = 0; m_inlock = 0;
    m_idx = 0; m_run = 0; m_cls = -1;
  endtask

  task automatic model_timeout();
    m_armed = 0; m_valid = 0; m_run = 0; m_inlock = 0;
`ifndef NOTE_DET_HOLD_EN
    m_idx = 0; m_ledon = 0;
`endif
  endtask

  task automatic model_rise();
    int c;
    exp_strb = 0;
    if (!m_armed) begin
      m_armed = 1;
      return;
    end
    c = classify(prev_p);
    if (c < 0) begin
      m_run = 0; m_inlock = 0;
      return;
    end
    m_run = (c == m_cls && m_run > 0) ? m_run + 1 : 1;
    m_cls = c;
    if (m_inlock && c != m_idx) m_inlock = 0;
    if (!m_inlock && m_run >= STABLE) begin
      m_inlock = 1; m_valid = 1; m_ledon = 1;
      m_idx = c; exp_strb = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_leds();
    return m_ledon ? (32'd1 << m_idx) : 32'd0;
  endfunction

  task automatic chk_out(input string tag);
    chk({tag, ".valid"}, {31'd0, note_valid}, {31'd0, m_valid});
    chk({tag, ".idx"}, {29'd0, note_idx}, m_idx);
    chk({tag, ".leds"},
        {26'd0, led5, led4, led3, led2, led1, led0}, exp_leds());
  endtask

  // One full period starting with a rise; caller is on a negedge.
  task automatic send(input string tag, input int p);
    int s0;
    model_rise();
    s0 = strobes;
    sound_in = 1'b1;
    repeat (p / 2) @(negedge clk);
    sound_in = 1'b0;
    repeat (p - p / 2) @(negedge clk);
    prev_p = p;
    chk_out(tag);
    chk({tag, ".strobe"}, strobes - s0, exp_strb);
  endtask

  // Period interrupted by a reset pulse in its low phase.
  task automatic send_rst(input int p);
    model_rise();
    sound_in = 1'b1;
    repeat (p / 2) @(negedge clk);
    sound_in = 1'b0;
    repeat (1000) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (p - p / 2 - 1002) @(negedge clk);
    chk_out("midrst");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  function automatic int jit(input int n);
    int j;
    j = (n / 64) / 2;
    return n + int'($urandom_range(0, 2 * j)) - j;
  endfunction

  initial begin
    sound_in = 1'b0;
    rst      = 1'b1;
    model_reset();
    prev_p = 0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_out("reset");
    chk("reset.strobe", {31'd0, note_strobe}, 32'd0);

    // A4: one arming rise then four matches lock.
    for (int k = 0; k < 6; k++) send("a4", jit(113636));

    // Silence timeout after the last rise.
    repeat (CNT_MAX - prev_p - 20) @(negedge clk);
    chk("to.before", {31'd0, note_valid}, {31'd0, m_valid});
    repeat (40) @(negedge clk);
    model_timeout();
    chk_out("to.after");

    // C4 lock, then switch to E4.
    for (int k = 0; k < 5; k++) send("c4", jit(191113));
    for (int k = 0; k < 5; k++) send("e4", jit(151685));

    // Alternating A4/G4 never locks.
    do_reset();
    for (int k = 0; k < 6; k++)
      send("alt", (k % 2 == 0) ? 113636 : 127551);

    // Tolerance boundary for A4.
    for (int k = 0; k < 3; k++) send("bnd.out", 115412);
    for (int k = 0; k < 5; k++) send("bnd.in", 115411);

    // Reset during the third G4 period, then relock.
    do_reset();
    send("g4.pre", jit(127551));
    send("g4.pre", jit(127551));
    send_rst(jit(127551));
    for (int k = 0; k < 5; k++) send("g4.post", jit(127551));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
